// File: rtl/dp8ka_ebr_pkg.sv
// Shared geometry and address/bit mapping helpers for the dual-port 8 Kbit
// embedded block RAM model.
package dp8ka_ebr_pkg;

    localparam int ROWS   = 512;
    localparam int ROW_W  = 18;
    localparam int AD_W   = 13;
    localparam int ROW_AW = 9;

    typedef enum logic [1:0] {
        WM_NORMAL,
        WM_WRITETHROUGH,
        WM_READBEFOREWRITE
    } wmode_e;

    typedef struct packed {
        logic [3:0] msb;
        logic [3:0] lsb;
    } addr_range_t;

    // Word address occupies AD[msb:lsb]; narrower words use more low bits.
    function automatic addr_range_t addr_range(input int width);
        addr_range_t r;
        r.msb = 4'd12;
        case (width)
            18:      r.lsb = 4'd4;
            9:       r.lsb = 4'd3;
            4:       r.lsb = 4'd2;
            2:       r.lsb = 4'd1;
            default: r.lsb = 4'd0;
        endcase
        return r;
    endfunction

    // Linear 16-bit data space skips the parity bit at position 8.
    function automatic int phys_bit(input int d);
        return (d < 8) ? d : d + 1;
    endfunction

endpackage

// File: rtl/dp8ka_ebr_port.sv
// One access port: chip-select decode, address split into row/bit lanes,
// write-mode output latch and optional output register.
module dp8ka_ebr_port
    import dp8ka_ebr_pkg::*;
#(
    parameter int    DATA_WIDTH = 18,
    parameter string REGMODE    = "NOREG",
    parameter string WRITEMODE  = "NORMAL",
    parameter string CSDECODE   = "000"
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic              i_we,
    input  logic [2:0]        i_cs,
    input  logic [AD_W-1:0]   i_ad,
    input  logic [ROW_W-1:0]  i_di,
    input  logic [ROW_W-1:0]  i_rd_row,
    output logic [ROW_AW-1:0] o_row,
    output logic              o_wr_en,
    output logic [ROW_W-1:0]  o_wr_mask,
    output logic [ROW_W-1:0]  o_wr_data,
    output logic [ROW_W-1:0]  o_do
);

    localparam addr_range_t AR  = addr_range(DATA_WIDTH);
    localparam int          MSB = int'(AR.msb);
    localparam int          LSB = int'(AR.lsb);
    localparam int          WPR = (DATA_WIDTH == 18) ? 1 : (DATA_WIDTH == 9) ? 2 : 16 / DATA_WIDTH;
    localparam logic [ROW_W-1:0] WORD_MASK = ROW_W'((1 << DATA_WIDTH) - 1);
    localparam logic        OUTREG = (REGMODE == "OUTREG");
    localparam wmode_e      WMODE  = (WRITEMODE == "WRITETHROUGH")    ? WM_WRITETHROUGH :
                                     (WRITEMODE == "READBEFOREWRITE") ? WM_READBEFOREWRITE :
                                                                        WM_NORMAL;
    localparam logic [2:0]  CS_MATCH = (CSDECODE == "001") ? 3'd1 :
                                       (CSDECODE == "010") ? 3'd2 :
                                       (CSDECODE == "011") ? 3'd3 :
                                       (CSDECODE == "100") ? 3'd4 :
                                       (CSDECODE == "101") ? 3'd5 :
                                       (CSDECODE == "110") ? 3'd6 :
                                       (CSDECODE == "111") ? 3'd7 : 3'd0;

    // x9 lanes sit on 9-bit boundaries including parity; narrower words do not.
    function automatic logic [4:0] bit_pos(input logic [3:0] slot, input int k);
        if (DATA_WIDTH >= 9) return 5'(int'(slot) * 9 + k);
        return 5'(phys_bit(int'(slot) * DATA_WIDTH + k));
    endfunction

    logic              w_active;
    logic [AD_W-1:0]   w_word;
    logic [3:0]        w_slot;
    logic [ROW_W-1:0]  w_mask;
    logic [ROW_W-1:0]  w_wdata;
    logic [ROW_W-1:0]  w_rword;
    logic [ROW_W-1:0]  w_di_word;
    logic [ROW_W-1:0]  r_latch_p1;
    logic [ROW_W-1:0]  r_out_p2;

    assign w_active  = i_ce && (i_cs == CS_MATCH);
    assign w_word    = i_ad >> LSB;
    assign w_slot    = 4'(w_word & AD_W'(WPR - 1));
    assign w_di_word = i_di & WORD_MASK;

    always_comb begin
        w_mask  = '0;
        w_wdata = '0;
        w_rword = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            w_mask[bit_pos(w_slot, k)]  = 1'b1;
            w_wdata[bit_pos(w_slot, k)] = i_di[k];
            w_rword[k]                  = i_rd_row[bit_pos(w_slot, k)];
        end
    end

    assign o_row     = i_ad[MSB -: ROW_AW];
    assign o_wr_en   = w_active && i_we;
    assign o_wr_mask = w_mask;
    assign o_wr_data = w_wdata;

    // Stage 1: data-output latch, captures array contents before this edge's writes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_latch_p1 <= '0;
        end else if (w_active) begin
            if (!i_we) begin
                r_latch_p1 <= w_rword;
            end else begin
                case (WMODE)
                    WM_WRITETHROUGH:    r_latch_p1 <= w_di_word;
                    WM_READBEFOREWRITE: r_latch_p1 <= w_rword;
                    default:            r_latch_p1 <= r_latch_p1;
                endcase
            end
        end
    end

    // Stage 2: optional output register, clocked by CE alone
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_p2 <= '0;
        end else if (i_ce) begin
            r_out_p2 <= r_latch_p1;
        end
    end

    assign o_do = OUTREG ? r_out_p2 : r_latch_p1;

endmodule

// File: rtl/dp8ka_ebr.sv
// Dual-port 512x18 block RAM with per-port width, write mode and output
// register selection; port A wins when both ports write the same bit.
module dp8ka_ebr
    import dp8ka_ebr_pkg::*;
#(
    parameter int    DATA_WIDTH_A = 18,
    parameter int    DATA_WIDTH_B = 18,
    parameter string REGMODE_A    = "NOREG",
    parameter string REGMODE_B    = "NOREG",
    parameter string WRITEMODE_A  = "NORMAL",
    parameter string WRITEMODE_B  = "NORMAL",
    parameter string CSDECODE_A   = "000",
    parameter string CSDECODE_B   = "000"
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CEA,
    input  logic              CEB,
    input  logic              WEA,
    input  logic              WEB,
    input  logic [2:0]        CSA,
    input  logic [2:0]        CSB,
    input  logic [AD_W-1:0]   ADA,
    input  logic [AD_W-1:0]   ADB,
    input  logic [ROW_W-1:0]  DIA,
    input  logic [ROW_W-1:0]  DIB,
    output logic [ROW_W-1:0]  DOA,
    output logic [ROW_W-1:0]  DOB
);

    logic [ROW_W-1:0]  r_mem [ROWS] = '{default: '0};

    logic [ROW_AW-1:0] w_a_row, w_b_row;
    logic              w_a_wr_en, w_b_wr_en;
    logic [ROW_W-1:0]  w_a_mask, w_b_mask;
    logic [ROW_W-1:0]  w_a_wdata, w_b_wdata;
    logic [ROW_W-1:0]  w_a_rd_row, w_b_rd_row;

    assign w_a_rd_row = r_mem[w_a_row];
    assign w_b_rd_row = r_mem[w_b_row];

    dp8ka_ebr_port #(
        .DATA_WIDTH (DATA_WIDTH_A),
        .REGMODE    (REGMODE_A),
        .WRITEMODE  (WRITEMODE_A),
        .CSDECODE   (CSDECODE_A)
    ) u_port_a (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_ce      (CEA),
        .i_we      (WEA),
        .i_cs      (CSA),
        .i_ad      (ADA),
        .i_di      (DIA),
        .i_rd_row  (w_a_rd_row),
        .o_row     (w_a_row),
        .o_wr_en   (w_a_wr_en),
        .o_wr_mask (w_a_mask),
        .o_wr_data (w_a_wdata),
        .o_do      (DOA)
    );

    dp8ka_ebr_port #(
        .DATA_WIDTH (DATA_WIDTH_B),
        .REGMODE    (REGMODE_B),
        .WRITEMODE  (WRITEMODE_B),
        .CSDECODE   (CSDECODE_B)
    ) u_port_b (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_ce      (CEB),
        .i_we      (WEB),
        .i_cs      (CSB),
        .i_ad      (ADB),
        .i_di      (DIB),
        .i_rd_row  (w_b_rd_row),
        .o_row     (w_b_row),
        .o_wr_en   (w_b_wr_en),
        .o_wr_mask (w_b_mask),
        .o_wr_data (w_b_wdata),
        .o_do      (DOB)
    );

    // Per-bit writes so that two ports on one row merge; A is applied last and wins.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < ROW_W; i++) begin
            if (w_b_wr_en && w_b_mask[i]) r_mem[w_b_row][i] <= w_b_wdata[i];
            if (w_a_wr_en && w_a_mask[i]) r_mem[w_a_row][i] <= w_a_wdata[i];
        end
    end

endmodule

// File: tb/tb_dp8ka_ebr.sv
// Directed bench for dp8ka_ebr: three instances cover widths, write modes,
// output register, chip select, collisions and reset.
module tb_dp8ka_ebr;

    logic        clk;
    logic        rst;
    logic        cea [3];
    logic        ceb [3];
    logic        wea [3];
    logic        web [3];
    logic [2:0]  csa [3];
    logic [2:0]  csb [3];
    logic [12:0] ada [3];
    logic [12:0] adb [3];
    logic [17:0] dia [3];
    logic [17:0] dib [3];
    logic [17:0] doa [3];
    logic [17:0] dob [3];

    int n_assert = 0;
    int n_fail   = 0;

    // dut0: A x18 NORMAL, B x9 NORMAL
    dp8ka_ebr #(.DATA_WIDTH_A(18), .DATA_WIDTH_B(9)) u_dut0 (
        .CLK(clk), .RST(rst), .CEA(cea[0]), .CEB(ceb[0]), .WEA(wea[0]), .WEB(web[0]),
        .CSA(csa[0]), .CSB(csb[0]), .ADA(ada[0]), .ADB(adb[0]),
        .DIA(dia[0]), .DIB(dib[0]), .DOA(doa[0]), .DOB(dob[0])
    );

    // dut1: A x18 READBEFOREWRITE, B x18 WRITETHROUGH
    dp8ka_ebr #(.WRITEMODE_A("READBEFOREWRITE"), .WRITEMODE_B("WRITETHROUGH")) u_dut1 (
        .CLK(clk), .RST(rst), .CEA(cea[1]), .CEB(ceb[1]), .WEA(wea[1]), .WEB(web[1]),
        .CSA(csa[1]), .CSB(csb[1]), .ADA(ada[1]), .ADB(adb[1]),
        .DIA(dia[1]), .DIB(dib[1]), .DOA(doa[1]), .DOB(dob[1])
    );

    // dut2: A x18 OUTREG with CSDECODE "101", B x4 NOREG
    dp8ka_ebr #(.REGMODE_A("OUTREG"), .CSDECODE_A("101"), .DATA_WIDTH_B(4)) u_dut2 (
        .CLK(clk), .RST(rst), .CEA(cea[2]), .CEB(ceb[2]), .WEA(wea[2]), .WEB(web[2]),
        .CSA(csa[2]), .CSB(csb[2]), .ADA(ada[2]), .ADB(adb[2]),
        .DIA(dia[2]), .DIB(dib[2]), .DOA(doa[2]), .DOB(dob[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            cea[d] = 1'b0;
            ceb[d] = 1'b0;
            wea[d] = 1'b0;
            web[d] = 1'b0;
        end
    endtask

    task automatic port_a(input int d, input logic we, input logic [12:0] ad, input logic [17:0] di);
        cea[d] = 1'b1;
        wea[d] = we;
        ada[d] = ad;
        dia[d] = di;
    endtask

    task automatic port_b(input int d, input logic we, input logic [12:0] ad, input logic [17:0] di);
        ceb[d] = 1'b1;
        web[d] = we;
        adb[d] = ad;
        dib[d] = di;
    endtask

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            csa[d] = 3'b000;
            csb[d] = 3'b000;
            ada[d] = '0;
            adb[d] = '0;
            dia[d] = '0;
            dib[d] = '0;
        end
        csa[2] = 3'b101;
        idle();
        tick();
        rst = 1'b0;
        chk("rst_doa0", doa[0], 18'h0);
        chk("rst_dob0", dob[0], 18'h0);
        chk("rst_doa1", doa[1], 18'h0);
        chk("rst_dob1", dob[1], 18'h0);
        chk("rst_doa2", doa[2], 18'h0);
        chk("rst_dob2", dob[2], 18'h0);

        // x18 write then read back
        port_a(0, 1'b1, 13'h0010, 18'h2ABCD); tick(); idle();
        chk("normal_wr_hold", doa[0], 18'h0);
        port_a(0, 1'b0, 13'h0010, 18'h0); tick(); idle();
        chk("x18_read", doa[0], 18'h2ABCD);

        // x18 write, x9 reads of both halves
        port_a(0, 1'b1, 13'h0000, 18'h3FE01); tick(); idle();
        chk("normal_wr_hold2", doa[0], 18'h2ABCD);
        port_b(0, 1'b0, 13'h0000, 18'h0); tick();
        chk("x9_read_lo", dob[0], 18'h00001);
        port_b(0, 1'b0, 13'h0008, 18'h0); tick(); idle();
        chk("x9_read_hi", dob[0], 18'h001FF);

        // x9 write to upper half of row 4, read back at x18
        port_b(0, 1'b1, 13'h0048, 18'h3FEAA); tick(); idle();
        chk("x9_wr_hold", dob[0], 18'h001FF);
        port_a(0, 1'b0, 13'h0040, 18'h0); tick(); idle();
        chk("x9_wr_x18_rd", doa[0], 18'h15400);

        // write modes
        port_a(1, 1'b1, 13'h0050, 18'h00011); tick();
        chk("rbw_first", doa[1], 18'h0);
        port_a(1, 1'b1, 13'h0050, 18'h00022); tick(); idle();
        chk("rbw_old", doa[1], 18'h00011);
        port_b(1, 1'b1, 13'h0050, 18'h00033); tick(); idle();
        chk("wt_new", dob[1], 18'h00033);

        // read on A while B writes the same row
        port_a(1, 1'b0, 13'h0050, 18'h0);
        port_b(1, 1'b1, 13'h0050, 18'h00044); tick(); idle();
        chk("rdw_reader_old", doa[1], 18'h00033);
        chk("rdw_writer_wt", dob[1], 18'h00044);

        // both ports write row 7 together
        port_a(1, 1'b1, 13'h0070, 18'h00001);
        port_b(1, 1'b1, 13'h0070, 18'h00002); tick(); idle();
        chk("coll_rbw_a", doa[1], 18'h0);
        chk("coll_wt_b", dob[1], 18'h00002);
        port_a(1, 1'b0, 13'h0070, 18'h0); tick();
        chk("coll_a_wins", doa[1], 18'h00001);
        port_a(1, 1'b0, 13'h0050, 18'h0); tick(); idle();
        chk("rdw_stored", doa[1], 18'h00044);

        // OUTREG latency and chip select
        port_a(2, 1'b1, 13'h0020, 18'h12345); tick(); idle();
        port_a(2, 1'b0, 13'h0020, 18'h0); tick();
        chk("outreg_cyc1", doa[2], 18'h0);
        tick(); idle();
        chk("outreg_cyc2", doa[2], 18'h12345);

        // x4 port: write slot 2 of row 3, read slot 1 of row 2
        port_b(2, 1'b1, 13'h0038, 18'h2AB0F); tick(); idle();
        chk("x4_wr_hold", dob[2], 18'h0);
        port_b(2, 1'b0, 13'h0024, 18'h0); tick(); idle();
        chk("x4_read", dob[2], 18'h00004);
        port_a(2, 1'b0, 13'h0030, 18'h0); tick(); tick(); idle();
        chk("x4_wr_x18_rd", doa[2], 18'h01E00);

        // write with mismatched chip select must not land
        csa[2] = 3'b100;
        port_a(2, 1'b1, 13'h0020, 18'h3FFFF); tick(); idle();
        csa[2] = 3'b101;
        chk("cs_miss_hold", doa[2], 18'h01E00);
        port_a(2, 1'b0, 13'h0020, 18'h0); tick();
        chk("cs_rd_cyc1", doa[2], 18'h01E00);
        tick(); idle();
        chk("cs_miss_nowr", doa[2], 18'h12345);

        // reset pulse with a concurrent read (A) and write (B)
        port_a(0, 1'b0, 13'h0010, 18'h0); tick(); idle();
        chk("pre_rst_doa", doa[0], 18'h2ABCD);
        rst = 1'b1;
        port_a(0, 1'b0, 13'h0000, 18'h0);
        port_b(0, 1'b1, 13'h0028, 18'h3FF55); tick();
        rst = 1'b0; idle();
        chk("rst_pulse_doa0", doa[0], 18'h0);
        chk("rst_pulse_dob0", dob[0], 18'h0);
        chk("rst_pulse_doa2", doa[2], 18'h0);
        port_a(0, 1'b0, 13'h0010, 18'h0); tick();
        chk("post_rst_mem", doa[0], 18'h2ABCD);
        port_a(0, 1'b0, 13'h0020, 18'h0); tick(); idle();
        chk("rst_wr_done", doa[0], 18'h2AA00);
        port_a(2, 1'b0, 13'h0020, 18'h0); tick(); tick(); idle();
        chk("post_rst_outreg", doa[2], 18'h12345);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dp8ka_ebr.md
DP8KA_EBR -- requirements
Module: dp8ka_ebr

Interface
REQ-001 Parameter DATA_WIDTH_A, default 18: port A word width; legal values 1, 2, 4, 9, 18.
REQ-002 Parameter DATA_WIDTH_B, default 18: port B word width; legal values 1, 2, 4, 9, 18.
REQ-003 Parameter REGMODE_A / REGMODE_B, default "NOREG": "NOREG" or "OUTREG" (adds an output pipeline register).
REQ-004 Parameter WRITEMODE_A / WRITEMODE_B, default "NORMAL": "NORMAL", "WRITETHROUGH" or "READBEFOREWRITE".
REQ-005 Parameter CSDECODE_A / CSDECODE_B, default "000": 3-character binary chip-select match value.
REQ-006 Ports, in this order:
- CLK, input, 1 bit: single clock for both ports; all logic on the rising edge.
- RST, input, 1 bit: synchronous, active-high reset of the output paths.
- CEA / CEB, input, 1 bit each: port clock enable.
- WEA / WEB, input, 1 bit each: write enable.
- CSA / CSB, input, 3 bits each: chip select; bit 0 = CS0.
- ADA / ADB, input, 13 bits each: address.
- DIA / DIB, input, 18 bits each: write data.
- DOA / DOB, output, 18 bits each: read data.

Function
REQ-007 Storage SHALL be 512 rows x 18 bits. Row bits [7:0] and [16:9] are data; bits 8 and 17 are parity. The array SHALL initialise to all zeros; there are no init parameters.
REQ-008 Address mapping by width:
- x18: row = AD[12:4], all 18 bits.
- x9: word = AD[12:3], row = word>>1; word[0]=0 selects bits [8:0], word[0]=1 selects bits [17:9].
- x4, x2, x1: word = AD[12:2], AD[12:1], AD[12:0] respectively, indexing a linear 16-bit data space per row. Data bit d maps to physical bit d for d<8 and to d+1 for d>=8; parity bits are not accessible.
- Address bits below the used range SHALL be ignored.
REQ-009 A port SHALL be active in a cycle when CEx=1 and CSx equals CSDECODE_x.
REQ-010 Active with WEx=1: the word DIx[W-1:0] SHALL be written at the rising edge. Active with WEx=0: the word SHALL be read.
REQ-011 Data-output latch after an active cycle:
- Read: the addressed word.
- Write, NORMAL: holds its previous value.
- Write, WRITETHROUGH: the new data.
- Write, READBEFOREWRITE: the old contents.
REQ-012 Read latency: NOREG, DO shows the latch value 1 cycle after the active edge. OUTREG, the latch feeds a register enabled by CEx, giving 2 cycles.
REQ-013 Inactive port (CE=0 or CS mismatch): no write, latch holds, DO holds.
REQ-014 DOx bits at and above the word width SHALL read 0.
REQ-015 Both ports write the same physical bit in one cycle: port A's value SHALL be stored.
REQ-016 One port reads a bit that the other port writes in the same cycle: the reader SHALL get the old value.
REQ-017 Mixed A/B widths SHALL share the one physical array, so data written at one width is readable at the other.

Reset
REQ-018 RST=1 at a rising edge SHALL clear both data-output latches and both output registers to 0, so DOA=DOB=0 on the next cycle.
REQ-019 RST SHALL NOT alter memory contents and SHALL take priority over any read in that cycle.
REQ-020 A write in the same cycle as RST=1 SHALL still complete.

Structure
REQ-021 Package dp8ka_ebr_pkg SHALL hold:
- ROWS=512, ROW_W=18;
- a function returning the address MSB/LSB for a given width;
- a function mapping a data-bit index to a physical bit.
REQ-022 One sub-module, dp8ka_ebr_port, SHALL be instantiated twice (A, B). It handles enable/CS decode, address split, write-mode output selection and the REGMODE pipeline. The top level owns the array and collision priority.

Verification
REQ-023 x18/x18, NOREG. A writes 18'h2ABCD at ADA=13'h0010; A reads it next cycle -> DOA=18'h2ABCD one cycle after the read edge.
REQ-024 A x18 writes 18'h3FE01 at row 0; B x9 reads ADB=0 and then ADB=8 -> DOB=9'h001, then 9'h1FF.
REQ-025 WRITEMODE_A="READBEFOREWRITE". Row 5 holds 18'h00011; A writes 18'h00022 to row 5 -> DOA=18'h00011. With "WRITETHROUGH" -> DOA=18'h00022. With "NORMAL" -> DOA unchanged.
REQ-026 OUTREG, and CSDECODE_A="101":
- Read of a known word appears on DOA exactly 2 cycles after the read edge.
- A write with CSA=3'b100 leaves memory unchanged.
REQ-027 A and B write 18'h00001 and 18'h00002 to the same row in one cycle -> a later read returns 18'h00001.
REQ-028 RST pulse while DOA=18'h2ABCD -> DOA=0 next cycle; a subsequent read still returns 18'h2ABCD.
